// File: rtl/flag_seq_pkg.sv
// Shared types and constants for the flag-check sequencer and its round datapath.
package flag_seq_pkg;

  typedef enum logic [1:0] {
    OP_ROR3 = 2'b00,
    OP_ROL2 = 2'b01,
    OP_ADD  = 2'b10,
    OP_XOR  = 2'b11
  } op_e;

  localparam logic [7:0] MAGIC_K = 8'h37;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/flag_seq_magic_round.sv
// One combinational magic round; shared by the sequencer, reusable by an unrolled datapath.
module magic_round
  import flag_seq_pkg::*;
(
  input  logic [7:0] inp,
  input  logic [1:0] sel,
  output logic [7:0] res
);

  always_comb begin
    res = inp;
    case (op_e'(sel))
      OP_ROR3: res = {inp[2:0], inp[7:3]};
      OP_ROL2: res = {inp[5:0], inp[7:6]};
      OP_ADD:  res = inp + MAGIC_K;
      OP_XOR:  res = inp ^ MAGIC_K;
      default: res = inp;
    endcase
  end

endmodule

// File: rtl/flag_seq_ctrl.sv
// Flag-check sequencer: 4 shared magic rounds per byte, compared against an expected table.
// Optional FLAG_SEQ_EARLY_EXIT_EN: stop the run at the first mismatching byte.
module flag_seq_ctrl
  import flag_seq_pkg::*;
#(
  parameter  int unsigned LEN   = 32,
  localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [IDX_W-1:0] exp_addr,
  input  logic [7:0]       exp_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   err_cnt
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       rnd_q, rnd_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       orig_q, orig_d;
  logic [IDX_W:0]   err_q, err_d;
  logic             pass_q, pass_d;

  logic [1:0] rnd_sel;
  logic [7:0] round_res;
  logic       mismatch;
  logic       last_byte;

  magic_round u_round (
    .inp (acc_q),
    .sel (rnd_sel),
    .res (round_res)
  );

  // Each round consumes the next 2-bit field of the original byte, LSBs first.
  always_comb begin
    rnd_sel = orig_q[1:0];
    case (rnd_q)
      2'd0: rnd_sel = orig_q[1:0];
      2'd1: rnd_sel = orig_q[3:2];
      2'd2: rnd_sel = orig_q[5:4];
      2'd3: rnd_sel = orig_q[7:6];
    endcase
  end

  assign mismatch  = (acc_q != exp_data);
  assign last_byte = (idx_q == IDX_W'(LEN - 1));
  assign exp_addr  = idx_q;
  assign err_cnt   = err_q;
  assign pass      = pass_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rnd_d     = rnd_q;
    acc_d     = acc_q;
    orig_d    = orig_q;
    err_d     = err_q;
    pass_d    = pass_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    done      = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          orig_d  = in_data;
          acc_d   = in_data;
          rnd_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        acc_d = round_res;
        rnd_d = rnd_q + 2'd1;
        if (rnd_q == 2'd3) state_d = CHECK;
      end
      CHECK: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
`ifdef FLAG_SEQ_EARLY_EXIT_EN
        if (mismatch || last_byte) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
`else
        if (last_byte) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
`endif
      end
      DONE: begin
        done    = 1'b1;
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rnd_q   <= '0;
      acc_q   <= '0;
      orig_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rnd_q   <= rnd_d;
      acc_q   <= acc_d;
      orig_q  <= orig_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_flag_seq_ctrl.sv
// Directed bench for flag_seq_ctrl (LEN=1 and LEN=4 instances) and magic_round.
module tb_flag_seq_ctrl;
  import flag_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // magic_round standalone
  logic [7:0] mr_inp, mr_res;
  logic [1:0] mr_sel;
  magic_round u_mr (.inp(mr_inp), .sel(mr_sel), .res(mr_res));

  typedef struct {
    logic [7:0] inp;
    logic [1:0] sel;
    logic [7:0] exp;
  } mr_vec_t;
  mr_vec_t mr_tab [8];

  // LEN=1 instance
  logic       start1, in_valid1, in_ready1, out_valid1, busy1, done1, pass1;
  logic [7:0] in_data1, exp_data1, out_data1;
  logic [0:0] exp_addr1;
  logic [1:0] err_cnt1;
  flag_seq_ctrl #(.LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .exp_addr(exp_addr1), .exp_data(exp_data1),
    .out_valid(out_valid1), .out_data(out_data1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err_cnt1)
  );

  // LEN=4 instance with a small expected-value ROM
  logic       start4, in_valid4, in_ready4, out_valid4, busy4, done4, pass4;
  logic [7:0] in_data4, exp_data4, out_data4;
  logic [1:0] exp_addr4;
  logic [2:0] err_cnt4;
  logic [7:0] exp_tab  [4];
  logic [7:0] byte_tab [4];
  logic [7:0] out_ref  [4];
  assign exp_data4 = exp_tab[exp_addr4];
  flag_seq_ctrl #(.LEN(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .exp_addr(exp_addr4), .exp_data(exp_data4),
    .out_valid(out_valid4), .out_data(out_data4), .busy(busy4), .done(done4),
    .pass(pass4), .err_cnt(err_cnt4)
  );

  int outs, fed, done_edge;

  // Runs one LEN=4 check; edges are counted from the edge that samples start.
  task automatic run4(input int stall);
    int edges;
    int stall_left;
    logic seen_done;
    edges = 0; stall_left = stall; seen_done = 1'b0;
    outs = 0; fed = 0; done_edge = -1;
    @(negedge clk); start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clk);
      if (out_valid4) begin
        if (outs < 4) chk($sformatf("run_out%0d", outs), 32'(out_data4), 32'(out_ref[outs]));
        outs++;
      end
      if (done4) begin
        seen_done = 1'b1;
        done_edge = edges;
      end
      if (stall_left > 0) begin
        chk("stall_in_ready", 32'(in_ready4), 32'd1);
        chk("stall_no_out", 32'(out_valid4), 32'd0);
        stall_left--;
        in_valid4 = 1'b0;
      end else if (in_ready4 && fed < 4) begin
        in_valid4 = 1'b1;
        in_data4  = byte_tab[fed];
        fed++;
      end else begin
        in_valid4 = 1'b0;
      end
      @(posedge clk); edges++;
    end
    if (!seen_done) chk("run_done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    start1 = 0; in_valid1 = 0; in_data1 = '0; exp_data1 = 8'hFE;
    start4 = 0; in_valid4 = 0; in_data4 = '0;
    byte_tab[0] = 8'h41; byte_tab[1] = 8'h5F; byte_tab[2] = 8'h62; byte_tab[3] = 8'h30;
    out_ref[0]  = 8'h50; out_ref[1]  = 8'hF5; out_ref[2]  = 8'hA9; out_ref[3]  = 8'hFE;
    for (int i = 0; i < 4; i++) exp_tab[i] = out_ref[i];

    mr_tab[0] = '{8'hFF, OP_ADD,  8'h36};
    mr_tab[1] = '{8'h01, OP_ROR3, 8'h20};
    mr_tab[2] = '{8'h80, OP_ROL2, 8'h02};
    mr_tab[3] = '{8'h30, OP_ROR3, 8'h06};
    mr_tab[4] = '{8'hC0, OP_XOR,  8'hF7};
    mr_tab[5] = '{8'h62, OP_ADD,  8'h99};
    mr_tab[6] = '{8'h7D, OP_ROL2, 8'hF5};
    mr_tab[7] = '{8'hF7, OP_ROR3, 8'hFE};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_in_ready", 32'(in_ready4), 32'd0);
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_out_data", 32'(out_data4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_pass", 32'(pass4), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt4), 32'd0);
    chk("rst_exp_addr", 32'(exp_addr4), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      mr_inp = mr_tab[i].inp;
      mr_sel = mr_tab[i].sel;
      #1 chk($sformatf("magic_round[%0d]", i), 32'(mr_res), 32'(mr_tab[i].exp));
    end

    // LEN=1: output 5 cycles after the handshake cycle, then done and pass
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk("len1_in_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1; in_data1 = 8'h30;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); k++;
      if (out_valid1) break;
    end
    chk("len1_latency", 32'(k), 32'd5);
    chk("len1_out_data", 32'(out_data1), 32'h0FE);
    @(negedge clk);
    chk("len1_done", 32'(done1), 32'd1);
    chk("len1_addr", 32'(exp_addr1), 32'd0);
    @(negedge clk);
    chk("len1_pass", 32'(pass1), 32'd1);
    chk("len1_err", 32'(err_cnt1), 32'd0);
    chk("len1_idle", 32'(busy1), 32'd0);

    // LEN=1: start coincident with DONE is ignored
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 8'h30;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done1) break;
    end
    chk("len1_done2", 32'(done1), 32'd1);
    start1 = 1'b1;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy1), 32'd0);
    start1 = 1'b0;
    @(negedge clk);
    chk("start_in_done_pass", 32'(pass1), 32'd1);

    // LEN=4 all ops, no errors
    run4(0);
    chk("len4_outs", 32'(outs), 32'd4);
    chk("len4_done_edge", 32'(done_edge), 32'd24);
    chk("len4_pass", 32'(pass4), 32'd1);
    chk("len4_err", 32'(err_cnt4), 32'd0);

    // LEN=4 single mismatch on byte 2
    exp_tab[2] = 8'h00;
    run4(0);
    chk("mm_err", 32'(err_cnt4), 32'd1);
    chk("mm_pass", 32'(pass4), 32'd0);
`ifdef FLAG_SEQ_EARLY_EXIT_EN
    chk("mm_outs", 32'(outs), 32'd3);
    chk("mm_fed", 32'(fed), 32'd3);
    chk("mm_done_edge", 32'(done_edge), 32'd18);
`else
    chk("mm_outs", 32'(outs), 32'd4);
    chk("mm_fed", 32'(fed), 32'd4);
    chk("mm_done_edge", 32'(done_edge), 32'd24);
`endif
    exp_tab[2] = 8'hA9;

    // LEN=4 with 10 stall cycles in LOAD
    run4(10);
    chk("stall_outs", 32'(outs), 32'd4);
    chk("stall_pass", 32'(pass4), 32'd1);

    // start during ROUND is ignored, then async reset during ROUND
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    in_valid4 = 1'b1; in_data4 = 8'h41;
    @(negedge clk); in_valid4 = 1'b0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    chk("rnd_start_addr", 32'(exp_addr4), 32'd0);
    chk("rnd_start_busy", 32'(busy4), 32'd1);
    chk("rnd_start_in_ready", 32'(in_ready4), 32'd0);
    for (int c = 0; c < 10; c++) begin
      if (out_valid4) break;
      @(negedge clk);
    end
    chk("rnd_start_out", 32'(out_data4), 32'h050);
    @(negedge clk);
    chk("rnd_start_next_ready", 32'(in_ready4), 32'd1);
    chk("rnd_start_next_addr", 32'(exp_addr4), 32'd1);
    in_valid4 = 1'b1; in_data4 = 8'h5F;
    @(negedge clk); in_valid4 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_addr", 32'(exp_addr4), 32'd0);
    chk("midrst_pass", 32'(pass4), 32'd0);
    chk("midrst_in_ready", 32'(in_ready4), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
